// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: fetch control, instruction-memory port and decode handshake.
interface fetch_unit_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        misalign_err;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, misalign_err
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, tagged instruction FIFO and redirect handling.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned redirect).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        mem_pc    [FIFO_DEPTH];
    logic [31:0]        mem_instr [FIFO_DEPTH];
    logic               push;
    logic               pop;
    logic               misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

    // Trap flag tracks the TRAP state one-for-one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= (state_d == TRAP);
    end

    assign bus.misalign_err = misalign_q;
`else
    logic unused_low_bits;

    // Low redirect bits are dropped silently when trapping is disabled.
    assign unused_low_bits  = ^bus.redirect_pc[1:0];
    assign misaligned       = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= fetch_pc_q;
            mem_instr[wr_ptr_q] <= bus.imem_data;
        end
    end

    // Next state, PC and FIFO bookkeeping; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pop        = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;
        push       = (state_q == RUN) & bus.fetch_en & ~bus.redirect_valid &
                     ((count_q < CNT_W'(FIFO_DEPTH)) | pop);

        if (bus.redirect_valid) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            if (misaligned) state_d = TRAP;
            else            state_d = bus.fetch_en ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.fetch_en)  state_d = RUN;
                RUN:     if (!bus.fetch_en) state_d = IDLE;
                TRAP:    state_d = TRAP;
                default: state_d = IDLE;
            endcase

            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    assign bus.imem_req  = push;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = (count_q != '0) ? mem_instr[rd_ptr_q] : 32'h0;
    assign bus.out_pc    = (count_q != '0) ? mem_pc[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hA5C3_0F96;
    endfunction

    assign bus.imem_data = instr_of(bus.imem_addr);

    typedef struct packed {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] opc;
        logic        mis;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic fe, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] opc, input logic mis);
        vec_t v;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.opc = opc; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                             input logic vld, input logic [31:0] opc, input logic mis);
        check({tag, ".req"},   32'(bus.imem_req),     32'(req));
        check({tag, ".addr"},  bus.imem_addr,         addr);
        check({tag, ".vld"},   32'(bus.out_valid),    32'(vld));
        check({tag, ".pc"},    bus.out_pc,            vld ? opc : 32'h0);
        check({tag, ".instr"}, bus.out_instr,         vld ? instr_of(opc) : 32'h0);
        check({tag, ".mis"},   32'(bus.misalign_err), 32'(mis));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream, backpressure, full-FIFO redirect, wrap, misaligned redirect, fetch_en low.
        vecs[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0);
        vecs[1]  = mk(1, 0, 32'h0,        1, 1, 32'h0,        0, 32'h0,        0);
        vecs[2]  = mk(1, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        0);
        vecs[3]  = mk(1, 0, 32'h0,        1, 1, 32'h8,        1, 32'h4,        0);
        vecs[4]  = mk(1, 0, 32'h0,        0, 1, 32'hC,        1, 32'h8,        0);
        vecs[5]  = mk(1, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
        vecs[6]  = mk(1, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
        vecs[7]  = mk(1, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
        vecs[8]  = mk(1, 0, 32'h0,        0, 0, 32'h10,       1, 32'h8,        0);
        vecs[9]  = mk(1, 0, 32'h0,        1, 1, 32'h10,       1, 32'h8,        0);
        vecs[10] = mk(1, 0, 32'h0,        1, 1, 32'h14,       1, 32'hC,        0);
        vecs[11] = mk(1, 1, 32'h100,      1, 0, 32'h18,       1, 32'h10,       0);
        vecs[12] = mk(1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        0);
        vecs[13] = mk(1, 0, 32'h0,        1, 1, 32'h104,      1, 32'h100,      0);
        vecs[14] = mk(1, 1, 32'hFFFF_FFF8, 1, 0, 32'h108,     1, 32'h104,      0);
        vecs[15] = mk(1, 0, 32'h0,        1, 1, 32'hFFFF_FFF8, 0, 32'h0,       0);
        vecs[16] = mk(1, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
        vecs[17] = mk(1, 0, 32'h0,        1, 1, 32'h0,        1, 32'hFFFF_FFFC, 0);
        vecs[18] = mk(1, 1, 32'h102,      1, 0, 32'h4,        1, 32'h0,        0);
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs[19] = mk(1, 0, 32'h0,        1, 0, 32'h100,      0, 32'h0,        1);
        vecs[20] = mk(1, 0, 32'h0,        1, 0, 32'h100,      0, 32'h0,        1);
        vecs[21] = mk(1, 1, 32'h200,      1, 0, 32'h100,      0, 32'h0,        1);
`else
        vecs[19] = mk(1, 0, 32'h0,        1, 1, 32'h100,      0, 32'h0,        0);
        vecs[20] = mk(1, 0, 32'h0,        1, 1, 32'h104,      1, 32'h100,      0);
        vecs[21] = mk(1, 1, 32'h200,      1, 0, 32'h108,      1, 32'h104,      0);
`endif
        vecs[22] = mk(1, 0, 32'h0,        1, 1, 32'h200,      0, 32'h0,        0);
        vecs[23] = mk(1, 0, 32'h0,        1, 1, 32'h204,      1, 32'h200,      0);
        vecs[24] = mk(0, 0, 32'h0,        1, 0, 32'h208,      1, 32'h204,      0);
        vecs[25] = mk(0, 0, 32'h0,        1, 0, 32'h208,      0, 32'h0,        0);
        vecs[26] = mk(0, 0, 32'h0,        0, 0, 32'h208,      0, 32'h0,        0);

        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.fetch_en       = vecs[i].fe;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.out_ready      = vecs[i].rdy;
            #1;
            check_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr,
                      vecs[i].vld, vecs[i].opc, vecs[i].mis);
            tick();
        end

        // Restart streaming, then pull reset mid-cycle with a live FIFO.
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        #1;
        check_all("rs_idle", 1'b0, 32'h208, 1'b0, 32'h0, 1'b0);
        tick();
        check_all("rs_run", 1'b1, 32'h208, 1'b0, 32'h0, 1'b0);
        tick();
        check_all("rs_live", 1'b1, 32'h20C, 1'b1, 32'h208, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rs_async", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_all("rs_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_all("rs_rel", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_all("rs_first", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_all("rs_second", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
